division: RTL and testbench

Sequential signed integer divider: continuously samples a WIDTH-bit two's-complement dividend `Q` and divisor `M`, computes quotient and remainder with a radix-2 restoring algorithm over WIDTH iterations, and presents registered results on `Quo`/`Rem`. Free-running datapath block with no start/busy handshake. Used where inputs are quasi-static relative to the WIDTH+2-cycle compute period.

---
 rtl/division.sv | 118 +++++++++++
 tb/tb_division.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/division.sv
// Free-running signed restoring divider: LOAD -> ITER x WIDTH -> FIX, one result every WIDTH+2 cycles.
// Define DIVISION_DONE_EN to add the one-cycle `done` strobe that accompanies each result update.
module division #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Q,
   input  logic [WIDTH-1:0] M,
   output logic [WIDTH-1:0] Quo,
   output logic [WIDTH-1:0] Rem
`ifdef DIVISION_DONE_EN
   ,
   output logic             done
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {LOAD, ITER, FIX} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   dvs;
   logic [WIDTH-1:0] qlat;
   logic             sign_q, sign_d;

   logic [WIDTH-1:0] abs_q;
   logic [WIDTH:0]   m_ext, abs_m;
   logic [WIDTH+1:0] shifted, trial;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Magnitudes: |Q| never exceeds 2^(WIDTH-1), so it fits WIDTH unsigned bits; |M| keeps WIDTH+1.
   always_comb begin
      m_ext = {M[WIDTH-1], M};
      abs_q = Q[WIDTH-1] ? ('0 - Q) : Q;
      abs_m = M[WIDTH-1] ? ('0 - m_ext) : m_ext;
   end

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      quo_fix = sign_d ? ('0 - quo) : quo;
      rem_fix = sign_q ? ('0 - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    state_next = ITER;
         ITER:    if (count == CW'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   // Working registers; a zero divisor is caught only at FIX so the iteration stays uniform.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         qlat   <= '0;
         sign_q <= 1'b0;
         sign_d <= 1'b0;
         Quo    <= '0;
         Rem    <= '0;
      end else begin
         case (state)
            LOAD: begin
               qlat   <= Q;
               sign_q <= Q[WIDTH-1];
               sign_d <= Q[WIDTH-1] ^ M[WIDTH-1];
               quo    <= abs_q;
               dvs    <= abs_m;
               rem    <= '0;
               count  <= '0;
            end
            ITER: begin
               if (trial[WIDTH+1]) begin
                  rem <= shifted[WIDTH:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end else begin
                  rem <= trial[WIDTH:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end
               count <= count + 1'b1;
            end
            FIX: begin
               if (dvs == '0) begin
                  Quo <= '1;
                  Rem <= qlat;
               end else begin
                  Quo <= quo_fix;
                  Rem <= rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DIVISION_DONE_EN
   always_ff @(posedge clk) begin
      if (rst) done <= 1'b0;
      else     done <= (state == FIX);
   end
`endif

endmodule

// File: tb/tb_division.sv
// Self-checking bench for division (WIDTH=8) against an integer-arithmetic reference model.
// Checks the done strobe as well when DIVISION_DONE_EN is defined.
module tb_division;

   logic       clk;
   logic       rst;
   logic [7:0] Q, M;
   logic [7:0] Quo, Rem;
   logic       done;

   int errors = 0;
   int checks = 0;
   logic [7:0] prevQuo, prevRem;

   division #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .Q   (Q),
      .M   (M),
      .Quo (Quo),
      .Rem (Rem)
`ifdef DIVISION_DONE_EN
      ,
      .done(done)
`endif
   );

`ifndef DIVISION_DONE_EN
   assign done = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating signed division; divide-by-zero yields all ones and the dividend as remainder.
   function automatic logic [15:0] refDiv(input logic [7:0] q, input logic [7:0] m);
      int qi, mi, qo, ro;
      qi = $signed(q);
      mi = $signed(m);
      if (mi == 0) return {8'hFF, q};
      qo = qi / mi;
      ro = qi % mi;
      return {qo[7:0], ro[7:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkDone(input string tag, input logic exp);
`ifdef DIVISION_DONE_EN
      checkOutput(tag, {7'd0, done}, {7'd0, exp});
`else
      if (exp === done) return;
`endif
   endtask

   // Entered just before a LOAD edge: holds operands for one period, checks hold then update.
   task automatic applyStimulus(input logic [7:0] q, input logic [7:0] m, input string tag);
      logic [15:0] exp;
      Q = q;
      M = m;
      repeat (9) @(posedge clk);
      #1;
      checkOutput({tag, ".holdQuo"}, Quo, prevQuo);
      checkOutput({tag, ".holdRem"}, Rem, prevRem);
      checkDone({tag, ".doneLow"}, 1'b0);
      @(posedge clk);
      #1;
      exp = refDiv(q, m);
      checkOutput({tag, ".Quo"}, Quo, exp[15:8]);
      checkOutput({tag, ".Rem"}, Rem, exp[7:0]);
      checkDone({tag, ".doneHigh"}, 1'b1);
      prevQuo = exp[15:8];
      prevRem = exp[7:0];
   endtask

   initial begin
      logic [15:0] exp;
      rst = 1'b1;
      Q = 8'd0;
      M = 8'd0;
      prevQuo = 8'd0;
      prevRem = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.Quo", Quo, 8'h00);
      checkOutput("reset.Rem", Rem, 8'h00);
      checkDone("reset.done", 1'b0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'd0, 8'd0, "divzero0");
      applyStimulus(-8'sd100, 8'sd10, "m100d10a");
      applyStimulus(-8'sd100, 8'sd10, "m100d10b");
      applyStimulus(-8'sd90, 8'sd9, "m90d9");
      applyStimulus(-8'sd70, 8'sd10, "m70d10");
      applyStimulus(-8'sd16, 8'sd3, "m16d3");
      applyStimulus(8'd56, 8'sd40, "q56d40");
      applyStimulus(8'd1, 8'sd5, "q1d5");
      applyStimulus(8'h80, 8'hFF, "overflow");
      applyStimulus(8'sd127, -8'sd2, "q127dm2");
      applyStimulus(8'h80, 8'sd127, "m128d127");
      applyStimulus(-8'sd37, 8'd0, "divzeroNeg");
      applyStimulus(8'h80, 8'h80, "m128dm128");

      // Operand change mid-ITER must not affect the result in flight.
      Q = -8'sd16;
      M = 8'sd3;
      repeat (4) @(posedge clk);
      #1;
      Q = 8'sd50;
      M = 8'sd7;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midIter.holdQuo", Quo, prevQuo);
      checkOutput("midIter.holdRem", Rem, prevRem);
      @(posedge clk);
      #1;
      exp = refDiv(-8'sd16, 8'sd3);
      checkOutput("midIter.oldQuo", Quo, exp[15:8]);
      checkOutput("midIter.oldRem", Rem, exp[7:0]);
      prevQuo = exp[15:8];
      prevRem = exp[7:0];
      applyStimulus(8'sd50, 8'sd7, "midIter.new");

      // Reset in the middle of ITER clears outputs on the next edge.
      Q = 8'sd100;
      M = 8'sd7;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midReset.Quo", Quo, 8'h00);
      checkOutput("midReset.Rem", Rem, 8'h00);
      checkDone("midReset.done", 1'b0);
      prevQuo = 8'd0;
      prevRem = 8'd0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'sd100, 8'sd7, "afterReset");

      for (int i = 0; i < 25; i++) begin
         applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
